alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, datapath width in bits.
REQ-002 SHALL have ports, clock and reset first; single clock, reset synchronous, active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  flush  in  1  drop in-flight op, return to IDLE
  in_valid  in  1  upstream op valid
  in_ready  out  1  stage accepts op this cycle
  in_op  in  3  ALU operation (000 sum, 001 sub), passed unchanged
  in_rs1, in_rs2, in_imm, in_pc  in  WORDSIZE  operand sources
  in_use_pc  in  1  operand A = in_pc, else in_rs1
  in_use_imm  in  1  operand B = in_imm, else in_rs2
  in_branch_cond  in  3  000 none, 001 eq, 010 ne, 011 lt, 100 ge, 101 ltu, 110 geu, 111 reserved
  alu_a, alu_b  out  WORDSIZE  ALU operands
  alu_op  out  3  ALU operation
  alu_result  in  WORDSIZE  ALU result
  alu_overflow, alu_equal, alu_less, alu_uns_less  in  1  ALU flags
  out_valid  out  1  result valid
  out_ready  in  1  downstream accepts result
  out_result  out  WORDSIZE  registered ALU result
  out_overflow  out  1  registered overflow flag
  out_branch_taken  out  1  registered branch decision

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-004 IDLE: in_ready=1; in_valid=1 latches op, selected operands, branch_cond; next EXEC.
REQ-005 EXEC: in_ready=0; alu_a/alu_b/alu_op driven from latched registers only; at clock edge capture alu_result and flags into out_* registers; next HOLD.
REQ-006 HOLD: out_valid=1; out_* stable until handshake; out_ready=0 stays HOLD.
REQ-007 HOLD with out_ready=1: in_ready=out_ready; if in_valid=1 also, latch new op and go EXEC (back-to-back); else go IDLE.
REQ-008 Latency: op accepted at edge N gives out_valid=1 after edge N+2; max throughput one op per 2 cycles.
REQ-009 Operand select: A = in_use_pc ? in_pc : in_rs1; B = in_use_imm ? in_imm : in_rs2; no width change.
REQ-010 Branch decision computed in EXEC from ALU flags: eq=equal, ne=!equal, lt=less, ge=!less, ltu=uns_less, geu=!uns_less; none and reserved give 0.
REQ-011 Outside EXEC, alu_a/alu_b/alu_op SHALL hold last latched values (no glitching to upstream inputs).
REQ-012 flush=1 (any state) next state IDLE, out_valid=0, in_ready=0 that cycle; flush overrides in_valid and out_ready.
REQ-013 in_op values other than 000/001 SHALL be forwarded unchanged; result is whatever the ALU returns.

Reset
REQ-014 reset=1 at clock edge: state IDLE; out_valid=0; out_result, alu_a, alu_b = 0; alu_op=000; out_overflow, out_branch_taken = 0; latched branch_cond=000.
REQ-015 reset SHALL take priority over flush and all handshakes; op in EXEC or HOLD discarded.
REQ-016 in_ready SHALL be 0 while reset=1.

Configuration
REQ-017 Macro ALU_ISSUE_STATS_EN defined: add outputs stat_ops (32 bit) and stat_ovf (32 bit); stat_ops increments on each HOLD->handshake completion, stat_ovf when that op has out_overflow=1; both saturate at 0xFFFFFFFF; cleared by reset, not by flush.
REQ-018 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-019 Reset then in_valid, rs1=5, rs2=3, op=001, out_ready=1 -> out_valid after 2 edges, out_result=2, overflow=0, back to IDLE.
REQ-020 use_pc=1, pc=0x1000, use_imm=1, imm=0x20, op=000 -> alu_a=0x1000, alu_b=0x20, out_result=0x1020.
REQ-021 rs1=0xFFFF..FF, rs2=1, op=001, cond=011 -> branch_taken=1; same with cond=101 -> branch_taken=0.
REQ-022 out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge, next result 2 cycles later.
REQ-023 flush during EXEC -> no out_valid; reset during HOLD -> out_valid=0 next cycle, out_result=0.
REQ-024 With ALU_ISSUE_STATS_EN: 3 ops, one overflowing (0x7FFF..FF + 1) -> stat_ops=3, stat_ovf=1; flush leaves them unchanged.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Issue stage sitting in front of an external ALU. It accepts one operation
//   from upstream and selects and latches its operands. It drives the ALU from
//   those latched registers, captures the ALU result and flags, and computes
//   the branch decision. The result is then held until downstream takes it.
//   The FSM walks IDLE -> EXEC -> HOLD. When a hand-off and a new op arrive in
//   the same HOLD cycle, it goes straight back to EXEC, which gives one op
//   every two cycles.
//
// Configuration:
//   ALU_ISSUE_STATS_EN : when defined, adds the stat_ops / stat_ovf counters.
//                        When undefined, those ports and counters are absent.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                drops any in-flight op and returns to IDLE
//   in_valid / in_ready  upstream handshake
//   in_op                ALU operation, forwarded unchanged
//   in_rs1, in_rs2,
//   in_imm, in_pc        operand sources
//   in_use_pc            operand A = in_pc, else in_rs1
//   in_use_imm           operand B = in_imm, else in_rs2
//   in_branch_cond       branch condition (none/eq/ne/lt/ge/ltu/geu/reserved)
//   alu_a, alu_b, alu_op operands and operation presented to the ALU
//   alu_result + flags   returned by the ALU
//   out_valid/out_ready  downstream handshake
//   out_result,
//   out_overflow,
//   out_branch_taken     registered results
//   stat_ops, stat_ovf   (ALU_ISSUE_STATS_EN only) completed ops / overflowing ops
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [WORDSIZE-1:0] in_rs1,
  input  logic [WORDSIZE-1:0] in_rs2,
  input  logic [WORDSIZE-1:0] in_imm,
  input  logic [WORDSIZE-1:0] in_pc,
  input  logic                in_use_pc,
  input  logic                in_use_imm,
  input  logic [2:0]          in_branch_cond,
  output logic [WORDSIZE-1:0] alu_a,
  output logic [WORDSIZE-1:0] alu_b,
  output logic [2:0]          alu_op,
  input  logic [WORDSIZE-1:0] alu_result,
  input  logic                alu_overflow,
  input  logic                alu_equal,
  input  logic                alu_less,
  input  logic                alu_uns_less,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_result,
  output logic                out_overflow,
  output logic                out_branch_taken
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [WORDSIZE-1:0] a_q;
  logic [WORDSIZE-1:0] b_q;
  logic [2:0]          op_q;
  logic [2:0]          cond_q;
  logic                accept;
  logic                handshake;
  logic                branch_taken;

  // The ALU only ever sees the latched operands. It never sees the live
  // upstream buses, so it does not glitch while upstream changes.
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  // Reset and flush both suppress in_ready. In HOLD the stage can take a new
  // op only in the same cycle that the held result leaves.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !flush) begin
      if (state == IDLE)
        in_ready = 1'b1;
      else if (state == HOLD)
        in_ready = out_ready;
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD) && !flush;
  assign handshake = (state == HOLD) && out_ready && !flush && !reset;

  // Branch decision from the ALU flags of the op that is now in EXEC.
  always_comb begin
    branch_taken = 1'b0;
    case (cond_q)
      3'b001:  branch_taken = alu_equal;
      3'b010:  branch_taken = !alu_equal;
      3'b011:  branch_taken = alu_less;
      3'b100:  branch_taken = !alu_less;
      3'b101:  branch_taken = alu_uns_less;
      3'b110:  branch_taken = !alu_uns_less;
      default: branch_taken = 1'b0;
    endcase
  end

  // Main FSM. Reset beats flush, and flush beats any handshake.
  // Flush leaves the result registers alone. The state change alone stops
  // them being presented downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      a_q              <= '0;
      b_q              <= '0;
      op_q             <= 3'b000;
      cond_q           <= 3'b000;
      out_result       <= '0;
      out_overflow     <= 1'b0;
      out_branch_taken <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= in_use_pc  ? in_pc  : in_rs1;
            b_q    <= in_use_imm ? in_imm : in_rs2;
            op_q   <= in_op;
            cond_q <= in_branch_cond;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_result       <= alu_result;
          out_overflow     <= alu_overflow;
          out_branch_taken <= branch_taken;
          state            <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) begin
              a_q    <= in_use_pc  ? in_pc  : in_rs1;
              b_q    <= in_use_imm ? in_imm : in_rs2;
              op_q   <= in_op;
              cond_q <= in_branch_cond;
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Completion counters. They saturate rather than wrap. Only reset clears
  // them; flush leaves them as they are.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops <= 32'd0;
      stat_ovf <= 32'd0;
    end else if (handshake) begin
      if (stat_ops != 32'hFFFF_FFFF)
        stat_ops <= stat_ops + 32'd1;
      if (out_overflow && (stat_ovf != 32'hFFFF_FFFF))
        stat_ovf <= stat_ovf + 32'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed testbench for alu_issue_stage with WORDSIZE = 64. A small
// behavioural ALU (add/sub, plus xor for other op codes) answers the stage's
// operand outputs. Each scenario task drives its vectors and compares the
// results against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int W = 64;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_rs1;
  logic [W-1:0]  in_rs2;
  logic [W-1:0]  in_imm;
  logic [W-1:0]  in_pc;
  logic          in_use_pc;
  logic          in_use_imm;
  logic [2:0]    in_branch_cond;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_overflow;
  logic          alu_equal;
  logic          alu_less;
  logic          alu_uns_less;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_overflow;
  logic          out_branch_taken;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]   stat_ops;
  logic [31:0]   stat_ovf;
`endif

  int n_checks;
  int n_fail;

  alu_issue_stage #(.WORDSIZE(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_imm           (in_imm),
    .in_pc            (in_pc),
    .in_use_pc        (in_use_pc),
    .in_use_imm       (in_use_imm),
    .in_branch_cond   (in_branch_cond),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .alu_result       (alu_result),
    .alu_overflow     (alu_overflow),
    .alu_equal        (alu_equal),
    .alu_less         (alu_less),
    .alu_uns_less     (alu_uns_less),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_overflow     (out_overflow),
    .out_branch_taken (out_branch_taken)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops         (stat_ops),
    .stat_ovf         (stat_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU the stage talks to.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_equal    = (alu_a == alu_b);
    alu_less     = ($signed(alu_a) < $signed(alu_b));
    alu_uns_less = (alu_a < alu_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_op          = 3'b000;
    in_rs1         = '0;
    in_rs2         = '0;
    in_imm         = '0;
    in_pc          = '0;
    in_use_pc      = 1'b0;
    in_use_imm     = 1'b0;
    in_branch_cond = 3'b000;
    out_ready      = 1'b1;
  endtask

  // Present one register-register op and leave the stage in HOLD.
  task automatic run_op(input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                        input logic [2:0] op, input logic [2:0] cond);
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_op          = op;
    in_branch_cond = cond;
    in_valid       = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || alu_a !== 64'd0 ||
        alu_b !== 64'd0 || alu_op !== 3'b000 || out_overflow !== 1'b0 ||
        out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got v=%b res=%h a=%h b=%h op=%b ovf=%b br=%b expected all zero",
               out_valid, out_result, alu_a, alu_b, alu_op, out_overflow, out_branch_taken);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    in_rs1 = 64'd5;
    in_rs2 = 64'd3;
    in_op = 3'b001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_a !== 64'd5 || alu_b !== 64'd3) begin
      n_fail++;
      $display("[TB] FAIL sub_exec: got v=%b rdy=%b a=%h b=%h expected v=0 rdy=0 a=5 b=3",
               out_valid, in_ready, alu_a, alu_b);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd2 || out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sub_result: got v=%b res=%h ovf=%b expected v=1 res=2 ovf=0",
               out_valid, out_result, out_overflow);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sub_back_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_operand_select();
    out_ready = 1'b1;
    in_use_pc = 1'b1;
    in_use_imm = 1'b1;
    in_pc = 64'h1000;
    in_imm = 64'h20;
    in_rs1 = 64'h7777;
    in_rs2 = 64'h8888;
    in_op = 3'b000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_pc = 64'hDEAD;
    in_imm = 64'hBEEF;
    #1;
    n_checks++;
    if (alu_a !== 64'h1000 || alu_b !== 64'h20 || alu_op !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL opsel_alu_inputs: got a=%h b=%h op=%b expected a=1000 b=20 op=000",
               alu_a, alu_b, alu_op);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 64'h1020) begin
      n_fail++;
      $display("[TB] FAIL opsel_result: got v=%b res=%h expected v=1 res=1020", out_valid, out_result);
    end
    tick();
    in_rs1 = 64'h1234;
    in_rs2 = 64'h5678;
    #1;
    n_checks++;
    if (alu_a !== 64'h1000 || alu_b !== 64'h20) begin
      n_fail++;
      $display("[TB] FAIL opsel_hold_idle: got a=%h b=%h expected a=1000 b=20", alu_a, alu_b);
    end
    in_use_pc = 1'b0;
    in_use_imm = 1'b0;
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b001, 3'b011);
    n_checks++;
    if (out_branch_taken !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("[TB] FAIL branch_lt: got br=%b res=%h expected br=1 res=fffffffffffffffe",
               out_branch_taken, out_result);
    end
    tick();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b001, 3'b101);
    n_checks++;
    if (out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL branch_ltu: got %b expected 0", out_branch_taken);
    end
    tick();
    run_op(64'd7, 64'd7, 3'b001, 3'b001);
    n_checks++;
    if (out_branch_taken !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL branch_eq: got %b expected 1", out_branch_taken);
    end
    tick();
    run_op(64'd7, 64'd7, 3'b001, 3'b111);
    n_checks++;
    if (out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL branch_reserved: got %b expected 0", out_branch_taken);
    end
    tick();
    run_op(64'd3, 64'd9, 3'b001, 3'b110);
    n_checks++;
    if (out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL branch_geu: got %b expected 0", out_branch_taken);
    end
    tick();
    in_branch_cond = 3'b000;
  endtask

  task automatic test_op_forward();
    out_ready = 1'b1;
    in_rs1 = 64'hF0;
    in_rs2 = 64'h0F;
    in_op = 3'b010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (alu_op !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL op_forward: got %b expected 010", alu_op);
    end
    tick();
    n_checks++;
    if (out_result !== 64'hFF) begin
      n_fail++;
      $display("[TB] FAIL op_forward_result: got %h expected ff", out_result);
    end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 3'b000);
    n_checks++;
    if (out_overflow !== 1'b1 || out_result !== 64'h8000_0000_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL overflow: got ovf=%b res=%h expected ovf=1 res=8000000000000000",
               out_overflow, out_result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    run_op(64'd10, 64'd4, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 64'd14 || in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_stall[%0d]: got v=%b res=%h rdy=%b expected v=1 res=e rdy=0",
                 i, out_valid, out_result, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    in_rs1 = 64'd20;
    in_rs2 = 64'd5;
    in_op = 3'b001;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || alu_a !== 64'd20 || alu_b !== 64'd5) begin
      n_fail++;
      $display("[TB] FAIL b2b_accept: got v=%b a=%h b=%h expected v=0 a=14 b=5",
               out_valid, alu_a, alu_b);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd15) begin
      n_fail++;
      $display("[TB] FAIL b2b_result: got v=%b res=%h expected v=1 res=f", out_valid, out_result);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_rs1 = 64'd8;
    in_rs2 = 64'd1;
    in_op = 3'b000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_exec: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_no_result: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    run_op(64'd9, 64'd2, 3'b001, 3'b000);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd7) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_hold: got v=%b res=%h expected v=1 res=7", out_valid, out_result);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || alu_a !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_hold: got v=%b res=%h a=%h expected all zero",
               out_valid, out_result, alu_a);
    end
    out_ready = 1'b1;
  endtask

`ifdef ALU_ISSUE_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (stat_ops !== 32'd0 || stat_ovf !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL stats_reset: got ops=%0d ovf=%0d expected 0 0", stat_ops, stat_ovf);
    end
    out_ready = 1'b1;
    run_op(64'd1, 64'd1, 3'b000, 3'b000);
    tick();
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 3'b000);
    tick();
    run_op(64'd3, 64'd1, 3'b001, 3'b000);
    tick();
    n_checks++;
    if (stat_ops !== 32'd3 || stat_ovf !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL stats_count: got ops=%0d ovf=%0d expected 3 1", stat_ops, stat_ovf);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (stat_ops !== 32'd3 || stat_ovf !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL stats_flush: got ops=%0d ovf=%0d expected 3 1", stat_ops, stat_ovf);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_sub();
    test_operand_select();
    test_branch();
    test_op_forward();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_hold();
`ifdef ALU_ISSUE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
